// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state type, BCD digit width and counter sizing helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam int BCD_DIGIT_W = 4;

   // Counter must hold values 0..n_digits.
   function automatic int cnt_width(input int n_digits);
      return $clog2(n_digits + 1);
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One conversion step: acc*10 + digit at BIN_W+4 bits, clamped to the
// BIN_W-bit maximum with a saturation flag.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W = 10
) (
   input  logic [BIN_W-1:0]       acc_in,
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BIN_W-1:0]       acc_out,
   output logic                   sat
);

   localparam int WIDE_W = BIN_W + 4;

   function automatic logic [BIN_W-1:0] sat_clamp(input logic [WIDE_W-1:0] v);
      return (|v[WIDE_W-1:BIN_W]) ? {BIN_W{1'b1}} : v[BIN_W-1:0];
   endfunction

   logic [WIDE_W-1:0] acc_ext;
   logic [WIDE_W-1:0] wide;

   // 10*acc never exceeds 2^(BIN_W+4) even for acc at max plus digit 15.
   assign acc_ext = {4'b0000, acc_in};
   assign wide    = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit};
   assign sat     = |wide[WIDE_W-1:BIN_W];
   assign acc_out = sat_clamp(wide);

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first,
// with valid/ready handshakes on both sides and saturating result.
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 3,
   parameter int BIN_W    = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BIN_W-1:0]              bin,
   output logic                          ovf,
   output logic                          err_digit
);

   localparam int CNT_W = cnt_width(N_DIGITS);
   localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);

   state_t                 state;
   logic [BCD_W-1:0]       digit_sr;
   logic [CNT_W-1:0]       cnt;
   logic [BIN_W-1:0]       acc;
   logic [BCD_DIGIT_W-1:0] digit;
   logic [BIN_W-1:0]       mac_acc;
   logic                   mac_sat;

   assign digit = digit_sr[BCD_W-1 -: BCD_DIGIT_W];
   assign bin   = acc;

   bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
      .acc_in (acc),
      .digit  (digit),
      .acc_out(mac_acc),
      .sat    (mac_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         err_digit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  digit_sr  <= bcd;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  err_digit <= 1'b0;
                  in_ready  <= 1'b0;
                  state     <= CONV;
               end
            end
            CONV: begin
               digit_sr  <= digit_sr << BCD_DIGIT_W;
               cnt       <= cnt + CNT_W'(1);
               // Once saturated the result is pinned at the maximum.
               acc       <= ovf ? {BIN_W{1'b1}} : mac_acc;
               ovf       <= ovf | mac_sat;
               err_digit <= err_digit | (digit > 4'd9);
               if (cnt == CNT_LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: BIN_W=8 and BIN_W=10 instances driven in lockstep,
// checked against a value-level model every cycle plus literal expectations.
module tb_bcd2bin_seq;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [11:0] bcd;

   logic        in_ready8, out_valid8, ovf8, err8;
   logic [7:0]  bin8;
   logic        in_ready10, out_valid10, ovf10, err10;
   logic [9:0]  bin10;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd2bin_seq #(.N_DIGITS(N), .BIN_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .bcd(bcd),
      .out_valid(out_valid8), .out_ready(out_ready), .bin(bin8), .ovf(ovf8),
      .err_digit(err8)
   );

   bcd2bin_seq #(.N_DIGITS(N), .BIN_W(10)) dut10 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10), .bcd(bcd),
      .out_valid(out_valid10), .out_ready(out_ready), .bin(bin10), .ovf(ovf10),
      .err_digit(err10)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Decimal value of the BCD word with raw nibble values as digit weights.
   function automatic int unsigned bcd_value(input logic [11:0] b);
      int unsigned w[3] = '{1, 10, 100};
      int unsigned v = 0;
      for (int i = 0; i < 3; i++) v += int'(b[4*i +: 4]) * w[i];
      return v;
   endfunction

   // Behavioural model: transaction-level phase plus expected results.
   bit          m_known = 0;
   bit          m_idle, m_ov;
   int          m_wait;
   int unsigned m_bin8, m_bin10, p_bin8, p_bin10;
   bit          m_o8, m_o10, m_err, p_o8, p_o10, p_err;

   always @(posedge clk) begin
      if (rst) begin
         m_known = 1; m_idle = 1; m_ov = 0; m_wait = 0;
         m_bin8 = 0; m_bin10 = 0; m_o8 = 0; m_o10 = 0; m_err = 0;
      end else if (m_known) begin
         if (m_idle) begin
            if (in_valid) begin
               int unsigned v;
               v = bcd_value(bcd);
               p_o8    = (v > 255);
               p_o10   = (v > 1023);
               p_bin8  = p_o8  ? 255  : v;
               p_bin10 = p_o10 ? 1023 : v;
               p_err   = 0;
               for (int i = 0; i < 3; i++) if (bcd[4*i +: 4] > 9) p_err = 1;
               m_idle = 0;
               m_wait = N;
            end
         end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               m_ov = 1;
               m_bin8 = p_bin8; m_bin10 = p_bin10;
               m_o8 = p_o8; m_o10 = p_o10; m_err = p_err;
            end
         end else if (out_ready) begin
            m_ov = 0;
            m_idle = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         chk("cyc_in_ready8",   in_ready8,   m_idle);
         chk("cyc_in_ready10",  in_ready10,  m_idle);
         chk("cyc_out_valid8",  out_valid8,  m_ov);
         chk("cyc_out_valid10", out_valid10, m_ov);
         if (m_idle || m_ov) begin
            chk("cyc_bin8",  bin8,  m_bin8);
            chk("cyc_bin10", bin10, m_bin10);
            chk("cyc_ovf8",  ovf8,  m_o8);
            chk("cyc_ovf10", ovf10, m_o10);
            chk("cyc_err8",  err8,  m_err);
            chk("cyc_err10", err10, m_err);
         end
      end
   end

   task automatic do_conv(input string nm, input logic [11:0] v,
                          input int e8, input int o8, input int e10, input int o10,
                          input int er, input int hold, input bit noisy);
      int edges;
      @(negedge clk);
      bcd = v;
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (noisy) bcd = 12'h999;
      else begin
         in_valid = 1'b0;
         bcd = 12'hFFF;
      end
      edges = 1;
      while (!out_valid8 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      in_valid = 1'b0;
      chk({nm, "_latency"}, edges, N + 1);
      chk({nm, "_bin8"},  bin8,  e8);
      chk({nm, "_ovf8"},  ovf8,  o8);
      chk({nm, "_bin10"}, bin10, e10);
      chk({nm, "_ovf10"}, ovf10, o10);
      chk({nm, "_err"},   err8,  er);
      repeat (hold) begin
         @(posedge clk); #1;
         chk({nm, "_hold_valid"}, out_valid8, 1);
         chk({nm, "_hold_ready"}, in_ready8,  0);
         chk({nm, "_hold_bin8"},  bin8,       e8);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_ready_after"}, in_ready8,  1);
      chk({nm, "_valid_after"}, out_valid8, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready8, 1);
      chk("rst_out_valid", out_valid8, 0);
      chk("rst_bin8", bin8, 0);
      chk("rst_ovf", ovf8, 0);
      chk("rst_err", err8, 0);
      rst = 1'b0;

      do_conv("c255", 12'h255, 8'hFF, 0, 10'h0FF, 0, 0, 0, 0);
      do_conv("c197", 12'h197, 8'hC5, 0, 10'h0C5, 0, 0, 0, 1);
      do_conv("c064", 12'h064, 8'h40, 0, 10'h040, 0, 0, 0, 0);
      do_conv("c001", 12'h001, 8'h01, 0, 10'h001, 0, 0, 0, 0);
      do_conv("c000", 12'h000, 8'h00, 0, 10'h000, 0, 0, 0, 0);
      do_conv("c256", 12'h256, 8'hFF, 1, 10'h100, 0, 0, 0, 0);
      do_conv("c1A3", 12'h1A3, 8'hCB, 0, 10'h0CB, 0, 1, 0, 0);
      do_conv("c999", 12'h999, 8'hFF, 1, 10'h3E7, 0, 0, 0, 0);
      do_conv("cFFF", 12'hFFF, 8'hFF, 1, 10'h3FF, 1, 1, 0, 0);
      do_conv("bp",   12'h197, 8'hC5, 0, 10'h0C5, 0, 0, 5, 0);

      // Reset in the second conversion cycle discards the request.
      @(negedge clk);
      bcd = 12'h197; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", out_valid8, 0);
      chk("midrst_in_ready", in_ready8, 1);
      chk("midrst_bin8", bin8, 0);
      repeat (6) @(posedge clk);
      do_conv("c042", 12'h042, 8'h2A, 0, 10'h02A, 0, 0, 0, 0);

      // Reset wins over a simultaneous request.
      @(negedge clk);
      bcd = 12'h123; in_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("rstprio_in_ready", in_ready8, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("rstprio_no_output", out_valid8, 0);

      // Reset while a result waits in DONE drops it.
      @(negedge clk);
      bcd = 12'h088; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (N + 1) @(posedge clk);
      #1;
      chk("done_valid", out_valid8, 1);
      chk("done_bin8", bin8, 8'h58);
      rst = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b0;
      chk("donerst_out_valid", out_valid8, 0);
      chk("donerst_bin8", bin8, 0);
      repeat (3) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 SHALL have parameter N_DIGITS, default 3, number of BCD digits on input (1..8).
REQ-002 SHALL have parameter BIN_W, default 10, binary result width (1..27).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  bcd holds a request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port bcd  input  4*N_DIGITS  packed BCD; bits [3:0] are the least significant digit (LSD), top nibble is the most significant digit (MSD).
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port bin  output  BIN_W  unsigned binary result.
REQ-011 SHALL have port ovf  output  1  value exceeded 2^BIN_W-1; bin saturated.
REQ-012 SHALL have port err_digit  output  1  at least one nibble was greater than 9.

Function
REQ-013 SHALL implement the FSM states IDLE, CONV and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL treat in_valid&&in_ready at a clock edge as acceptance.
- REQ-015a On acceptance, SHALL capture bcd into a digit shift register.
- REQ-015b On acceptance, SHALL clear the accumulator, digit counter, ovf and err_digit.
- REQ-015c On acceptance, SHALL go to CONV.
REQ-016 SHALL, in CONV, process one digit per cycle, MSD first, computing acc <= acc*10 + d.
- REQ-016a SHALL form *10 as (acc<<3)+(acc<<1), with no multiplier.
REQ-017 SHALL, in CONV, shift the digit register by 4 bits each cycle.
REQ-018 SHALL, in CONV, increment the counter each cycle, and leave CONV for DONE after exactly N_DIGITS cycles.
REQ-019 SHALL give a latency of N_DIGITS+1 edges from the acceptance edge to the edge after which out_valid=1.
REQ-020 SHALL, for a digit d>9, set err_digit (sticky for the conversion) and still use the raw value d in the arithmetic.
REQ-021 SHALL compute each step at BIN_W+4 bits and then apply the saturation rule.
- REQ-021a If a step result exceeds 2^BIN_W-1, SHALL set ovf (sticky) and clamp acc to 2^BIN_W-1.
- REQ-021b After ovf is set, SHALL hold acc at 2^BIN_W-1.
REQ-022 SHALL, in DONE, drive out_valid=1, and keep bin, ovf and err_digit stable until out_valid&&out_ready.
REQ-023 SHALL move from DONE to IDLE on out_valid&&out_ready; in_ready is 1 in the following cycle.
REQ-024 SHALL ignore in_valid outside IDLE, and SHALL NOT sample bcd outside the acceptance edge.
REQ-025 SHALL hold bin at the last result in IDLE (between transactions), with out_valid=0.
- REQ-025a ovf and err_digit SHALL likewise hold their last values in IDLE.

Reset
REQ-026 SHALL, on rst=1 at an edge, enter IDLE regardless of state, including mid-CONV and in DONE.
REQ-027 SHALL, on reset, give: in_ready=1 (from the next cycle), out_valid=0, bin=0, ovf=0, err_digit=0, acc=0, counter=0.
REQ-028 SHALL discard any in-flight conversion on reset, with no output produced.
REQ-029 SHALL give rst priority over every handshake event in the same cycle.

Structure
REQ-030 SHALL take the following from shared package bcd_pkg:
- REQ-030a the state enum typedef (IDLE, CONV, DONE);
- REQ-030b the constant BCD_DIGIT_W=4;
- REQ-030c a function computing the counter width, $clog2(N_DIGITS+1).
REQ-031 SHALL place the per-step multiply-by-10-add-digit and saturation logic in one combinational sub-module, bcd_mac10 (params BIN_W; ports acc_in, digit, acc_out, sat).
REQ-032 SHALL have the parent hold the FSM, the counter, the shift register and the handshake logic.

Verification (instance N_DIGITS=3, BIN_W=8 unless stated)
REQ-033 SHALL check bcd=12'h255 accepted -> 4 edges later out_valid=1, bin=8'hFF, ovf=0, err_digit=0.
REQ-034 SHALL check bcd=12'h197 -> bin=8'hC5; bcd=12'h064 -> 8'h40; bcd=12'h001 -> 8'h01; bcd=12'h000 -> 8'h00.
REQ-035 SHALL check bcd=12'h256 -> bin=8'hFF, ovf=1; with BIN_W=10 the same input gives bin=10'h100, ovf=0.
REQ-036 SHALL check bcd=12'h1A3 -> err_digit=1; bin equals 1*100+10*10+3=203 (8'hCB).
REQ-037 SHALL check backpressure: out_ready=0 for 5 cycles -> out_valid, bin held, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-038 SHALL check rst=1 in the second CONV cycle of bcd=12'h197 -> next cycle IDLE, out_valid=0, bin=0; a new request of 12'h042 then yields 8'h2A.
